mem_acceso: RTL
===============

Name: mem_acceso

Overview:
- Load/store access controller directly upstream of the 3-register memory-mapped block (words at 0x10000000/04/08).
- Accepts one request at a time from the CPU datapath over a valid/ready handshake and validates the address.
- Drives the memory's active-low strobes, address and write data; captures read data and returns a response.
- Guarantees Mem_rd and Mem_wr are never low together, since the memory gives read priority.

Parameters:
- BASE, 32'h10000000, byte address of first mapped word
- NUM_REGS, 3, number of mapped 32-bit words (offsets 0,4,...,4*(NUM_REGS-1))

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1=store, 0=load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  32  load data (0 for stores/errors)
- resp_err  out  1  unmapped or misaligned address
- Mem_rd  out  1  memory read strobe, active-low
- Mem_wr  out  1  memory write strobe, active-low
- Dir_Mem  out  32  memory address
- Dato_Mem_in  out  32  memory write data
- Dato_Mem_out  in  32  memory read data (valid one edge after strobe)

Behaviour:
- Clock port is clk; reset port is rst, asynchronous, active-high.
- Reset values:
  - Mem_rd=1, Mem_wr=1.
  - Dir_Mem=0, Dato_Mem_in=0.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - State IDLE, so req_ready=1.
- States: IDLE, ACC, WAIT, RESP. All outputs are registered.
- req_ready = (state==IDLE), combinational from state.
- IDLE:
  - On an edge with req_valid=1, latch req_addr into Dir_Mem and req_wdata into Dato_Mem_in.
  - Address legal (aligned, offset < 4*NUM_REGS): drive Mem_rd=0 if load, Mem_wr=0 if store; next state ACC.
  - Address illegal: no strobe, resp_err=1, resp_rdata=0, resp_valid=1; next state RESP.
- ACC: exactly one cycle. The memory samples on the closing edge. At that edge both strobes return to 1.
  - Store: resp_valid=1, resp_err=0, resp_rdata=0; next state RESP.
  - Load: next state WAIT.
- WAIT: at the closing edge, resp_rdata<=Dato_Mem_out, resp_valid=1, resp_err=0; next state RESP.
- RESP:
  - Hold resp_* stable until an edge with resp_ready=1.
  - At that edge resp_valid<=0; next state IDLE.
  - resp_rdata and resp_err hold their values until the next response.
- Latency, counted from the accept edge E to resp_valid high:
  - Store: after E+1.
  - Load: after E+2.
  - Error: after E.
- Throughput: the next accept is possible no earlier than the edge after the response handshake.
- Dir_Mem and Dato_Mem_in are held between accepts. The strobe is low for exactly one clock per legal request.
- req_valid while not IDLE is ignored; the requester must hold it.
- Misaligned means req_addr[1:0]!=0. The address compare is a full 32-bit unsigned subtract from BASE; below-BASE wraps and is treated as illegal.
- rst asserted mid-operation: strobes return to 1 immediately (asynchronous). Any in-flight response is discarded and no resp_valid is issued for it.

Optional Feature:
- Macro MEM_ACC_CNT_EN.
- When defined:
  - Add outputs cnt_rd, cnt_wr, cnt_err, each 16 bits.
  - Each counts completed response handshakes of its kind (load OK, store OK, error).
  - Reset to 0; wrap 0xFFFF->0.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package mem_acc_pkg holds:
  - State enum (IDLE, ACC, WAIT, RESP).
  - Default BASE.
  - Word-stride constant 4.
  - Strobe-inactive constant 1'b1.
- Sub-module mem_acc_dec (combinational): inputs addr, outputs legal and word index. Reused later by any other master of the same bus.

Test Plan:
- Store 0xDEADBEEF to 0x10000004 with resp_ready=1 -> Mem_wr low one cycle with Dir_Mem=0x10000004 and Dato_Mem_in=0xDEADBEEF; resp_valid after E+1 with resp_err=0.
- Load from 0x10000004 after that store, against a memory model -> Mem_rd low one cycle; resp_rdata=0xDEADBEEF at E+2.
- Load from 0x1000000C and from 0x10000002 -> no strobe either time; resp_err=1 and resp_rdata=0 after E.
- Hold resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata stable; req_ready=0; a new req_valid is not accepted until one edge after resp_ready=1.
- Assert rst during ACC of a store -> Mem_wr=1 immediately; resp_valid stays 0; req_ready=1 after reset release.
- With MEM_ACC_CNT_EN defined, run 2 loads, 3 stores and 1 error -> cnt_rd=2, cnt_wr=3, cnt_err=1.

Source files
------------

// File: rtl/mem_acc_pkg.sv
// Shared types and constants for the mem_acceso load/store controller and its address decoder.
package mem_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [31:0] DEF_BASE    = 32'h1000_0000;
  localparam int          WORD_STRIDE = 4;
  localparam logic        STROBE_OFF  = 1'b1;

endpackage

// File: rtl/mem_acc_dec.sv
// Address decoder for the memory-mapped register block: word-aligned, in-window check plus word index.
// Kept separate so any other bus master can reuse the same legality rule.
module mem_acc_dec
  import mem_acc_pkg::*;
#(
  parameter logic [31:0] BASE     = DEF_BASE,
  parameter int          NUM_REGS = 3,
  localparam int         IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic [31:0]      addr,
  output logic             legal,
  output logic [IDX_W-1:0] idx
);

  logic [31:0] offset;

  // Addresses below BASE wrap to a huge offset and therefore fail the window compare.
  always_comb begin
    offset = addr - BASE;
    legal  = (addr[1:0] == 2'b00) && (offset < 32'(WORD_STRIDE * NUM_REGS));
    idx    = offset[IDX_W+1:2];
  end

endmodule

// File: rtl/mem_acceso.sv
// Load/store access controller in front of the 3-word memory-mapped block (active-low strobes).
// Optional macro MEM_ACC_CNT_EN adds 16-bit counters of completed load/store/error responses.
module mem_acceso
  import mem_acc_pkg::*;
#(
  parameter logic [31:0] BASE     = DEF_BASE,
  parameter int          NUM_REGS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        Mem_rd,
  output logic        Mem_wr,
  output logic [31:0] Dir_Mem,
  output logic [31:0] Dato_Mem_in,
  input  logic [31:0] Dato_Mem_out
`ifdef MEM_ACC_CNT_EN
  ,
  output logic [15:0] cnt_rd,
  output logic [15:0] cnt_wr,
  output logic [15:0] cnt_err
`endif
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_t           state, state_nx;
  logic             legal;
  logic [IDX_W-1:0] unused_word_idx;
  logic             op_we;

  mem_acc_dec #(
    .BASE     (BASE),
    .NUM_REGS (NUM_REGS)
  ) u_dec (
    .addr  (req_addr),
    .legal (legal),
    .idx   (unused_word_idx)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: the default assignment up front keeps this block free of inferred latches.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = legal ? ACC : RESP;
      ACC:     state_nx = op_we ? RESP : WAIT;
      WAIT:    state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
  end

  // Registered outputs; the async reset also pulls both strobes inactive immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Mem_rd      <= STROBE_OFF;
      Mem_wr      <= STROBE_OFF;
      Dir_Mem     <= '0;
      Dato_Mem_in <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      op_we       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            Dir_Mem     <= req_addr;
            Dato_Mem_in <= req_wdata;
            op_we       <= req_we;
            if (legal) begin
              Mem_rd <= req_we ? STROBE_OFF : ~STROBE_OFF;
              Mem_wr <= req_we ? ~STROBE_OFF : STROBE_OFF;
            end else begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end
          end
        end
        ACC: begin
          Mem_rd <= STROBE_OFF;
          Mem_wr <= STROBE_OFF;
          if (op_we) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end
        end
        WAIT: begin
          resp_rdata <= Dato_Mem_out;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
        end
        RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ACC_CNT_EN
  logic resp_hs;

  always_comb begin
    resp_hs = (state == RESP) && resp_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_rd  <= '0;
      cnt_wr  <= '0;
      cnt_err <= '0;
    end else if (resp_hs) begin
      if (resp_err)   cnt_err <= cnt_err + 16'd1;
      else if (op_we) cnt_wr  <= cnt_wr + 16'd1;
      else            cnt_rd  <= cnt_rd + 16'd1;
    end
  end
`endif

endmodule
